// File: rtl/reg_dump.sv
// reg_dump: reads register indices first..last (5-bit wrap) through ra/rd and presents each word with valid/ready.
// Define REG_DUMP_PARITY_EN to drive even parity of out_data on out_par; otherwise out_par is tied low.
module reg_dump (
  input  logic        clk,
  input  logic        rstd,
  input  logic        start,
  input  logic [4:0]  first_idx,
  input  logic [4:0]  last_idx,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_par,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [4:0] idx;
  logic [4:0] last;
  logic       accept;

  assign accept = out_valid && out_ready;
  assign ra     = idx;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state     <= IDLE;
      idx       <= 5'd0;
      last      <= 5'd0;
      out_data  <= 32'd0;
      out_idx   <= 5'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= first_idx;
            last  <= last_idx;
            state <= READ;
          end
        end
        READ: begin
          out_data  <= rd;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // Word and index stay frozen until the consumer takes them.
          if (accept) begin
            out_valid <= 1'b0;
            if (idx == last) begin
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_DUMP_PARITY_EN
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      out_par <= 1'b0;
    end else if (state == READ) begin
      out_par <= ^rd;
    end
  end
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: table of dump ranges plus random ranges, checked against an index-sequence model.
module tb_reg_dump;

  logic        clk;
  logic        rstd;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_par;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  reg_dump dut (
    .clk(clk), .rstd(rstd), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .ra(ra), .rd(rd), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_par(out_par), .busy(busy), .done(done)
  );

  // Register file model
  assign rd = {27'h0, ra} ^ 32'hA5A50000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         mode;     // 0: ready always, 1: random ready, 2: stall 5 cycles first
    bit         restart;  // pulse start again mid-dump
    int         exp_n;    // number of words expected
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    return (i % 32) ^ 32'hA5A50000;
  endfunction

  function automatic logic model_par(input logic [31:0] w);
`ifdef REG_DUMP_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit restart, input int exp_n);
    int acc, cyc, dones, stall, last_acc;
    bit prev_hold, restarted;
    logic [31:0] prev_data;
    logic [4:0]  prev_idx;
    logic        rdy;
    int          exp_i;
    acc = 0; cyc = 0; dones = 0; stall = 0; last_acc = 0;
    prev_hold = 0; restarted = 0; prev_data = '0; prev_idx = '0;
    @(negedge clk);
    start = 1'b1; first_idx = f; last_idx = l;
    @(negedge clk);
    start = 1'b0; first_idx = 5'($urandom); last_idx = 5'($urandom);
    chk("busy_after_start", busy, 1'b1);
    chk("valid_in_read", out_valid, 1'b0);
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("first_valid_latency", out_valid, 1'b1);
      if (done) begin
        dones++;
        chk("done_after_accept", cyc - last_acc, 1);
        break;
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
        chk("hold_idx", out_idx, prev_idx);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = (stall >= 5);
      endcase
      if (out_valid && !rdy) stall++;
      out_ready = rdy;
      if (out_valid && rdy) begin
        exp_i = (int'(f) + acc) % 32;
        chk("word_idx", out_idx, exp_i);
        chk("word_data", out_data, model_word(exp_i));
        chk("word_par", out_par, model_par(model_word(exp_i)));
        if (mode == 0 && acc > 0) chk("word_spacing", cyc - last_acc, 2);
        acc++;
        last_acc = cyc;
        prev_hold = 0;
      end else begin
        prev_hold = out_valid;
        prev_data = out_data;
        prev_idx  = out_idx;
      end
      if (restart && !restarted && acc == 10) begin
        start = 1'b1; first_idx = 5'($urandom); last_idx = 5'($urandom);
        restarted = 1;
      end
    end
    start = 1'b0;
    chk("done_count", dones, 1);
    chk("word_count", acc, exp_n);
    if (mode == 2) chk("stall_cycles", stall >= 5, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [4:0] rf, rl;
    int n;
    vecs[0] = '{5'd3,  5'd5,  0, 1'b0, 3};
    vecs[1] = '{5'd30, 5'd1,  0, 1'b0, 4};
    vecs[2] = '{5'd7,  5'd7,  2, 1'b0, 1};
    vecs[3] = '{5'd0,  5'd31, 0, 1'b1, 32};
    vecs[4] = '{5'd31, 5'd0,  1, 1'b0, 2};
    vecs[5] = '{5'd5,  5'd4,  1, 1'b1, 32};

    rstd = 1'b0; start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ra", ra, 5'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_idx", out_idx, 5'd0);
    chk("rst_par", out_par, 1'b0);
    repeat (2) @(negedge clk);
    rstd = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_valid", out_valid, 1'b0);
    chk("idle_not_busy", busy, 1'b0);

    for (int v = 0; v < 6; v++)
      run_dump(vecs[v].first, vecs[v].last, vecs[v].mode, vecs[v].restart, vecs[v].exp_n);

    for (int r = 0; r < 8; r++) begin
      rf = 5'($urandom); rl = 5'($urandom);
      n = ((int'(rl) - int'(rf) + 32) % 32) + 1;
      run_dump(rf, rl, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), n);
    end

    // Reset during HOLD of index 10 of an 8..12 dump
    @(negedge clk);
    start = 1'b1; first_idx = 5'd8; last_idx = 5'd12; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int w;
      for (w = 0; w < 50; w++) begin
        @(negedge clk);
        if (out_valid && out_idx == 5'd10) break;
      end
      chk("reach_idx10", w < 50, 1'b1);
    end
    out_ready = 1'b0;
    rstd = 1'b0;
    #1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ra", ra, 5'd0);
    chk("abort_idx", out_idx, 5'd0);
    @(negedge clk);
    rstd = 1'b1;
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (done || out_valid || busy) seen++;
      end
      chk("no_activity_after_abort", seen, 0);
    end
    run_dump(5'd0, 5'd0, 0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
